// File: rtl/ddc_pack_pkg.sv
// Shared widths, header layout, output FSM states and the sign-extension
// helper for the DDC frame packer.
package ddc_pack_pkg;

    localparam int ACC_WIDTH = 48;
    localparam int IN_WIDTH  = 96;
    localparam int OUT_WIDTH = 64;
    localparam int CNT_WIDTH = 32;

    // Accumulator fields inside one input beat
    localparam int I_LSB = 0;
    localparam int Q_LSB = ACC_WIDTH;

    // Header word layout: {MAGIC, N_CH, out_frame_cnt}
    localparam int HDR_MAGIC_LSB = 48;
    localparam int HDR_NCH_LSB   = 32;
    localparam int HDR_CNT_LSB   = 0;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        WI,
        WQ
    } state_e;

    function automatic logic [OUT_WIDTH-1:0] sext_acc(input logic [ACC_WIDTH-1:0] acc);
        return {{(OUT_WIDTH - ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc};
    endfunction

endpackage

// File: rtl/ddc_frame_packer_if.sv
// Stream bundle around the packer: accumulator beats in, AXI-Stream packets
// out, plus the two error counters. The packer uses the slave view.
interface ddc_frame_packer_if;
    import ddc_pack_pkg::*;

    logic [IN_WIDTH-1:0]  s_axis_ddc_tdata;
    logic                 s_axis_ddc_tvalid;
    logic                 s_axis_ddc_tready;
    logic [OUT_WIDTH-1:0] m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;
    logic                 m_axis_tlast;
    logic [CNT_WIDTH-1:0] drop_cnt;
    logic [CNT_WIDTH-1:0] trunc_cnt;

    modport slave (
        input  s_axis_ddc_tdata, s_axis_ddc_tvalid, m_axis_tready,
        output s_axis_ddc_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output drop_cnt, trunc_cnt
    );

    modport master (
        output s_axis_ddc_tdata, s_axis_ddc_tvalid, m_axis_tready,
        input  s_axis_ddc_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  drop_cnt, trunc_cnt
    );

endinterface

// File: rtl/ddc_frame_fifo.sv
// Commit/rewind circular buffer of 96-bit beats. Writes land at the
// speculative pointer; a commit publishes a whole frame, a rewind discards
// the uncommitted tail. Reads are by offset from the read pointer, which
// advances one frame at a time when the frame has been sent.
module ddc_frame_fifo import ddc_pack_pkg::*; #(
    parameter  int DEPTH = 64,
    parameter  int N_CH  = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int PW    = AW + 1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                wr_en_i,
    input  logic [IN_WIDTH-1:0] wr_data_i,
    input  logic                commit_i,
    input  logic                rewind_i,
    input  logic                rd_en_i,
    input  logic [AW-1:0]       rd_off_i,
    input  logic                release_i,
    output logic [IN_WIDTH-1:0] rd_data_o,
    output logic [PW-1:0]       free_space_o,
    output logic [PW-1:0]       frames_avail_o
);

    logic [IN_WIDTH-1:0] mem_q [DEPTH];
    logic [IN_WIDTH-1:0] rd_data_q;
    logic [PW-1:0]       wr_spec_q, wr_spec_d;
    logic [PW-1:0]       wr_commit_q, wr_commit_d;
    logic [PW-1:0]       rd_q, rd_d;
    logic [PW-1:0]       avail_q, avail_d;
    logic [AW-1:0]       rd_addr;

    // Next-state for the pointers and the committed-frame count
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
        wr_spec_d   = wr_spec_q;
        wr_commit_d = wr_commit_q;
        rd_d        = rd_q;
        avail_d     = avail_q;
        if (rewind_i) begin
            wr_spec_d = wr_commit_q;
        end else if (wr_en_i) begin
            wr_spec_d = wr_spec_q + 1'b1;
        end
        if (commit_i) begin
            wr_commit_d = wr_spec_q + 1'b1;
        end
        if (release_i) begin
            rd_d = rd_q + PW'(N_CH);
        end
        unique case ({commit_i, release_i})
            2'b10:   avail_d = avail_q + 1'b1;
            2'b01:   avail_d = avail_q - 1'b1;
            default: avail_d = avail_q;
        endcase
    end

    // Pointer registers with synchronous reset
    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n_i) begin
            wr_spec_q   <= '0;
            wr_commit_q <= '0;
            rd_q        <= '0;
            avail_q     <= '0;
        end else begin
            wr_spec_q   <= wr_spec_d;
            wr_commit_q <= wr_commit_d;
            rd_q        <= rd_d;
            avail_q     <= avail_d;
        end
    end

    assign rd_addr = rd_q[AW-1:0] + rd_off_i;

    // Storage array and registered read port
    always_ff @(posedge clk_i) begin
        // NOTE: the array and its read register carry no reset; the pointers alone decide what is valid.
        if (wr_en_i) begin
            mem_q[wr_spec_q[AW-1:0]] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data_o      = rd_data_q;
    assign free_space_o   = PW'(DEPTH) - (wr_spec_q - rd_q);
    assign frames_avail_o = avail_q;

endmodule

// File: rtl/ddc_frame_packer.sv
// Frames N_CH-beat accumulator bursts into the buffer and streams each
// frame out as a header plus sign-extended I/Q words with tlast.
module ddc_frame_packer import ddc_pack_pkg::*; #(
    parameter int          N_CH       = 4,
    parameter int          FIFO_DEPTH = 64,
    parameter logic [15:0] MAGIC      = 16'hDD0C
) (
    input  logic               s_axis_aclk,
    input  logic               s_axis_aresetn,
    ddc_frame_packer_if.slave  bus
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int BW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [BW-1:0] LAST_CH = BW'(N_CH - 1);

    logic [BW-1:0]        beat_cnt_q, beat_cnt_d;
    logic                 drop_mode_q, drop_mode_d;
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_WIDTH-1:0] trunc_cnt_q, trunc_cnt_d;
    logic                 wr_en, commit, rewind;

    state_e               state_q, state_d;
    logic [BW-1:0]        ch_q, ch_d;
    logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic [OUT_WIDTH-1:0] tdata_q, tdata_d;
    logic                 tvalid_q, tvalid_d;
    logic                 tlast_q, tlast_d;
    logic                 adv, rd_en, release_frame;
    logic [AW-1:0]        rd_off;
    logic [IN_WIDTH-1:0]  rd_data;
    logic [PW-1:0]        free_space, frames_avail;

    function automatic logic [OUT_WIDTH-1:0] make_hdr(input logic [CNT_WIDTH-1:0] cnt);
        logic [OUT_WIDTH-1:0] w;
        w                          = '0;
        w[HDR_MAGIC_LSB +: 16]     = MAGIC;
        w[HDR_NCH_LSB +: 16]       = 16'(N_CH);
        w[HDR_CNT_LSB +: CNT_WIDTH] = cnt;
        return w;
    endfunction

    ddc_frame_fifo #(.DEPTH(FIFO_DEPTH), .N_CH(N_CH)) u_fifo (
        .clk_i         (s_axis_aclk),
        .rst_n_i       (s_axis_aresetn),
        .wr_en_i       (wr_en),
        .wr_data_i     (bus.s_axis_ddc_tdata),
        .commit_i      (commit),
        .rewind_i      (rewind),
        .rd_en_i       (rd_en),
        .rd_off_i      (rd_off),
        .release_i     (release_frame),
        .rd_data_o     (rd_data),
        .free_space_o  (free_space),
        .frames_avail_o(frames_avail)
    );

    // Input framing: beat counting, write/drop decision, truncation handling
    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        drop_mode_d = drop_mode_q;
        drop_cnt_d  = drop_cnt_q;
        trunc_cnt_d = trunc_cnt_q;
        wr_en       = 1'b0;
        commit      = 1'b0;
        rewind      = 1'b0;
        if (bus.s_axis_ddc_tvalid) begin
            if (beat_cnt_q == '0) begin
                drop_mode_d = (free_space < PW'(N_CH));
            end
            wr_en = !drop_mode_d;
            if (beat_cnt_q == LAST_CH) begin
                beat_cnt_d = '0;
                commit     = !drop_mode_d;
                if (drop_mode_d && drop_cnt_q != '1) begin
                    drop_cnt_d = drop_cnt_q + 1'b1;
                end
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end else if (beat_cnt_q != '0) begin
            // Short burst: forget its partial frame, keep committed data
            beat_cnt_d = '0;
            rewind     = !drop_mode_q;
            if (trunc_cnt_q != '1) begin
                trunc_cnt_d = trunc_cnt_q + 1'b1;
            end
        end
    end

    assign adv = !tvalid_q || bus.m_axis_tready;

    // Output FSM: picks the next word and prefetches the next buffer entry
    always_comb begin
        state_d       = state_q;
        ch_d          = ch_q;
        frame_cnt_d   = frame_cnt_q;
        tdata_d       = tdata_q;
        tvalid_d      = tvalid_q;
        tlast_d       = tlast_q;
        rd_en         = 1'b0;
        rd_off        = '0;
        release_frame = 1'b0;
        if (adv) begin
            unique case (state_q)
                IDLE: begin
                    if (frames_avail != '0) begin
                        state_d  = HDR;
                        ch_d     = '0;
                        tdata_d  = make_hdr(frame_cnt_q);
                        tvalid_d = 1'b1;
                        tlast_d  = 1'b0;
                        rd_en    = 1'b1;
                    end
                end
                HDR: begin
                    state_d = WI;
                    tdata_d = sext_acc(rd_data[I_LSB +: ACC_WIDTH]);
                end
                WI: begin
                    state_d = WQ;
                    tdata_d = sext_acc(rd_data[Q_LSB +: ACC_WIDTH]);
                    tlast_d = (ch_q == LAST_CH);
                    if (ch_q != LAST_CH) begin
                        rd_en  = 1'b1;
                        rd_off = AW'(ch_q) + AW'(1);
                    end
                end
                WQ: begin
                    if (ch_q != LAST_CH) begin
                        state_d = WI;
                        ch_d    = ch_q + 1'b1;
                        tdata_d = sext_acc(rd_data[I_LSB +: ACC_WIDTH]);
                    end else begin
                        // tlast accepted: hand the frame's space back
                        release_frame = 1'b1;
                        frame_cnt_d   = frame_cnt_q + 1'b1;
                        tlast_d       = 1'b0;
                        ch_d          = '0;
                        if (frames_avail > PW'(1)) begin
                            state_d = HDR;
                            tdata_d = make_hdr(frame_cnt_q + 1'b1);
                            rd_en   = 1'b1;
                            rd_off  = AW'(N_CH);
                        end else begin
                            state_d  = IDLE;
                            tvalid_d = 1'b0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Framing, counter, FSM and output registers
    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            beat_cnt_q  <= '0;
            drop_mode_q <= 1'b0;
            drop_cnt_q  <= '0;
            trunc_cnt_q <= '0;
            state_q     <= IDLE;
            ch_q        <= '0;
            frame_cnt_q <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            drop_mode_q <= drop_mode_d;
            drop_cnt_q  <= drop_cnt_d;
            trunc_cnt_q <= trunc_cnt_d;
            state_q     <= state_d;
            ch_q        <= ch_d;
            frame_cnt_q <= frame_cnt_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
        end
    end

    assign bus.s_axis_ddc_tready = 1'b1;
    assign bus.m_axis_tdata      = tdata_q;
    assign bus.m_axis_tvalid     = tvalid_q;
    assign bus.m_axis_tlast      = tlast_q;
    assign bus.drop_cnt          = drop_cnt_q;
    assign bus.trunc_cnt         = trunc_cnt_q;

endmodule

// File: tb/tb_ddc_frame_packer.sv
// Scoreboard bench for ddc_frame_packer: a 64-deep instance for framing,
// latency, back-to-back, backpressure and reset; an 8-deep instance for
// overflow, truncation and wrap-around.
module tb_ddc_frame_packer;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } exp_t;

    logic clk;
    logic rst_n;
    logic rdy_a, rdy_b, bp_en, bp_ready;
    int   n_tests, n_fail, cyc;
    int   words_a, words_b, cnt_a, cnt_b;
    bit   track_a;
    int   trk_n, trk_first, trk_last;
    exp_t qa[$];
    exp_t qb[$];

    ddc_frame_packer_if ifa();
    ddc_frame_packer_if ifb();

    ddc_frame_packer #(.N_CH(4), .FIFO_DEPTH(64), .MAGIC(16'hDD0C)) dut_a (
        .s_axis_aclk   (clk),
        .s_axis_aresetn(rst_n),
        .bus           (ifa)
    );

    ddc_frame_packer #(.N_CH(4), .FIFO_DEPTH(8), .MAGIC(16'hDD0C)) dut_b (
        .s_axis_aclk   (clk),
        .s_axis_aresetn(rst_n),
        .bus           (ifb)
    );

    assign ifa.m_axis_tready = bp_en ? bp_ready : rdy_a;
    assign ifb.m_axis_tready = rdy_b;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // tready pattern 1,0,0,1 while backpressure is enabled
    initial begin
        logic pat [4];
        int   idx;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        idx = 0;
        bp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                bp_ready = pat[idx];
                idx = (idx + 1) % 4;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 1 ms");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor A: pop and compare accepted words, check stall stability
    initial begin
        logic [63:0] held_d;
        logic        held_l;
        bit          stall;
        exp_t        e;
        stall = 0;
        forever begin
            @(negedge clk);
            if (stall && rst_n) begin
                check("stall_data_a", ifa.m_axis_tdata, held_d);
                check("stall_last_a", 64'(ifa.m_axis_tlast), 64'(held_l));
            end
            stall  = rst_n && ifa.m_axis_tvalid && !ifa.m_axis_tready;
            held_d = ifa.m_axis_tdata;
            held_l = ifa.m_axis_tlast;
            if (rst_n && ifa.m_axis_tvalid && ifa.m_axis_tready) begin
                if (qa.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word_a: got %h, expected no word", ifa.m_axis_tdata);
                end else begin
                    e = qa.pop_front();
                    check("word_a", ifa.m_axis_tdata, e.data);
                    check("tlast_a", 64'(ifa.m_axis_tlast), 64'(e.last));
                end
                words_a++;
                if (track_a) begin
                    if (trk_n == 0) trk_first = cyc;
                    trk_last = cyc;
                    trk_n++;
                end
            end
        end
    end

    // Monitor B
    initial begin
        logic [63:0] held_d;
        logic        held_l;
        bit          stall;
        exp_t        e;
        stall = 0;
        forever begin
            @(negedge clk);
            if (stall && rst_n) begin
                check("stall_data_b", ifb.m_axis_tdata, held_d);
                check("stall_last_b", 64'(ifb.m_axis_tlast), 64'(held_l));
            end
            stall  = rst_n && ifb.m_axis_tvalid && !ifb.m_axis_tready;
            held_d = ifb.m_axis_tdata;
            held_l = ifb.m_axis_tlast;
            if (rst_n && ifb.m_axis_tvalid && ifb.m_axis_tready) begin
                if (qb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word_b: got %h, expected no word", ifb.m_axis_tdata);
                end else begin
                    e = qb.pop_front();
                    check("word_b", ifb.m_axis_tdata, e.data);
                    check("tlast_b", 64'(ifb.m_axis_tlast), 64'(e.last));
                end
                words_b++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [47:0] beat_i(input int seed, input int ch);
        if (seed == 0) return 48'(ch + 1);
        if (ch == 3) return 48'h7FFF_FFFF_FFFF - 48'(seed);
        return 48'(seed * 256 + ch + 1);
    endfunction

    function automatic logic [47:0] beat_q(input int seed, input int ch);
        if (seed == 0) return 48'(-(ch + 1));
        return 48'h8000_0000_0000 | 48'(seed * 16 + ch);
    endfunction

    function automatic logic [63:0] sx(input logic [47:0] v);
        return {{16{v[47]}}, v};
    endfunction

    task automatic push_exp(input bit sel, input logic [63:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        if (sel) qb.push_back(e);
        else     qa.push_back(e);
    endtask

    // Expected packet for a full frame built from the seed's beat values
    task automatic push_frame(input bit sel, input int seed);
        int c;
        c = sel ? cnt_b : cnt_a;
        push_exp(sel, {16'hDD0C, 16'h0004, 32'(c)}, 1'b0);
        for (int ch = 0; ch < 4; ch++) begin
            push_exp(sel, sx(beat_i(seed, ch)), 1'b0);
            push_exp(sel, sx(beat_q(seed, ch)), ch == 3);
        end
        if (sel) cnt_b++;
        else     cnt_a++;
    endtask

    task automatic drive(input bit sel, input logic [95:0] d, input logic v);
        if (sel) begin
            ifb.s_axis_ddc_tdata  = d;
            ifb.s_axis_ddc_tvalid = v;
        end else begin
            ifa.s_axis_ddc_tdata  = d;
            ifa.s_axis_ddc_tvalid = v;
        end
    endtask

    task automatic send_frame(input bit sel, input int nbeats, input int seed);
        for (int ch = 0; ch < nbeats; ch++) begin
            drive(sel, {beat_q(seed, ch), beat_i(seed, ch)}, 1'b1);
            tick();
        end
        drive(sel, '0, 1'b0);
    endtask

    task automatic drain(input bit sel, input int budget);
        int n;
        n = 0;
        while (((sel ? qb.size() : qa.size()) != 0) && n < budget) begin
            tick();
            n++;
        end
        check(sel ? "drain_b" : "drain_a", 64'(sel ? qb.size() : qa.size()), 64'd0);
        idle(3);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        qa.delete();
        qb.delete();
        cnt_a = 0;
        cnt_b = 0;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int w0, n;
        n_tests = 0; n_fail = 0;
        words_a = 0; words_b = 0; cnt_a = 0; cnt_b = 0;
        track_a = 0; trk_n = 0; trk_first = 0; trk_last = 0;
        rst_n = 1'b0; bp_en = 1'b0; rdy_a = 1'b1; rdy_b = 1'b1;
        drive(1'b0, '0, 1'b0);
        drive(1'b1, '0, 1'b0);
        idle(3);

        // Reset values
        check("rst_tvalid_a", 64'(ifa.m_axis_tvalid), 64'd0);
        check("rst_tdata_a", ifa.m_axis_tdata, 64'd0);
        check("rst_tlast_a", 64'(ifa.m_axis_tlast), 64'd0);
        check("rst_drop_a", 64'(ifa.drop_cnt), 64'd0);
        check("rst_trunc_a", 64'(ifa.trunc_cnt), 64'd0);
        check("rst_tvalid_b", 64'(ifb.m_axis_tvalid), 64'd0);
        check("s_tready_a", 64'(ifa.s_axis_ddc_tready), 64'd1);
        rst_n = 1'b1;
        tick();

        // Single frame, hand-computed words, header latency
        push_exp(0, 64'hDD0C_0004_0000_0000, 0);
        push_exp(0, 64'h0000_0000_0000_0001, 0);
        push_exp(0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        push_exp(0, 64'h0000_0000_0000_0002, 0);
        push_exp(0, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        push_exp(0, 64'h0000_0000_0000_0003, 0);
        push_exp(0, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        push_exp(0, 64'h0000_0000_0000_0004, 0);
        push_exp(0, 64'hFFFF_FFFF_FFFF_FFFC, 1);
        cnt_a = 1;
        send_frame(0, 4, 0);
        check("lat_edge_t", 64'(ifa.m_axis_tvalid), 64'd0);
        tick();
        check("lat_edge_t1", 64'(ifa.m_axis_tvalid), 64'd1);
        check("lat_hdr", ifa.m_axis_tdata, 64'hDD0C_0004_0000_0000);
        drain(0, 50);

        // Back-to-back: three frames, one idle cycle apart, no bubbles
        do_reset();
        track_a = 1;
        trk_n = 0;
        for (int f = 0; f < 3; f++) begin
            push_frame(0, f + 1);
            send_frame(0, 4, f + 1);
            idle(1);
        end
        drain(0, 100);
        track_a = 0;
        check("b2b_words", 64'(trk_n), 64'd27);
        check("b2b_span", 64'(trk_last - trk_first), 64'd26);

        // Backpressure: tready 1,0,0,1 repeating
        bp_en = 1'b1;
        for (int f = 0; f < 2; f++) begin
            push_frame(0, f + 4);
            send_frame(0, 4, f + 4);
            idle(1);
        end
        drain(0, 200);
        bp_en = 1'b0;

        // Reset while word 5 of a packet is on the bus
        push_frame(0, 6);
        w0 = words_a;
        send_frame(0, 4, 6);
        n = 0;
        while (words_a < w0 + 4 && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("rst_wait", 64'(words_a - w0), 64'd4);
        #1;
        rst_n = 1'b0;
        tick();
        check("mid_rst_tvalid", 64'(ifa.m_axis_tvalid), 64'd0);
        check("mid_rst_tdata", ifa.m_axis_tdata, 64'd0);
        check("mid_rst_tlast", 64'(ifa.m_axis_tlast), 64'd0);
        qa.delete();
        qb.delete();
        cnt_a = 0;
        cnt_b = 0;
        rst_n = 1'b1;
        idle(3);
        check("post_rst_idle", 64'(ifa.m_axis_tvalid), 64'd0);
        push_frame(0, 7);
        send_frame(0, 4, 7);
        drain(0, 50);

        // Overflow on the 8-deep instance: third frame dropped
        rdy_b = 1'b0;
        push_frame(1, 8);
        send_frame(1, 4, 8);
        idle(1);
        push_frame(1, 9);
        send_frame(1, 4, 9);
        idle(1);
        send_frame(1, 4, 10);
        idle(2);
        check("ovf_drop", 64'(ifb.drop_cnt), 64'd1);
        check("ovf_hdr_wait", 64'(ifb.m_axis_tvalid), 64'd1);
        rdy_b = 1'b1;
        w0 = words_b;
        drain(1, 100);
        check("ovf_words", 64'(words_b - w0), 64'd18);

        // Truncation, then two full frames must still fit
        send_frame(1, 2, 11);
        idle(2);
        check("trunc_cnt", 64'(ifb.trunc_cnt), 64'd1);
        check("trunc_no_out", 64'(ifb.m_axis_tvalid), 64'd0);
        rdy_b = 1'b0;
        push_frame(1, 12);
        send_frame(1, 4, 12);
        idle(1);
        push_frame(1, 13);
        send_frame(1, 4, 13);
        idle(2);
        check("trunc_no_leak", 64'(ifb.drop_cnt), 64'd1);
        rdy_b = 1'b1;
        w0 = words_b;
        drain(1, 100);
        check("trunc_words", 64'(words_b - w0), 64'd18);
        check("trunc_cnt_end", 64'(ifb.trunc_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
